// File: rtl/rv_decode_stage.sv
// rv_decode_stage
// ---------------------------------------------------------------------------
// Registered RISC-V decode stage between fetch and execute.
//
// Fetch beats ({IN_PC, IN_INSTR}) arrive over a valid/ready handshake and are
// decoded combinationally.  The decoded fields are then registered into a
// 2-entry buffer:
//   * main : drives the OUT_* ports
//   * skid : holds one overflow beat while main is stalled
// This arrangement sustains one beat per cycle under back-pressure while
// keeping IN_READY a pure register output.  No IN_* signal has a
// combinational path to any OUT_* signal.
//
// Parameters
//   XLEN          32 or 64; sets the PC and immediate widths and the shift
//                 amount width.
//   RESET_PC_VAL  value shown on OUT_PC whenever no decoded beat is valid.
//
// Ports
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   FLUSH                 synchronous; drops every buffered beat and any beat
//                         offered in the same cycle
//   IN_VALID/IN_READY     fetch handshake; IN_INSTR (32 bits), IN_PC (XLEN)
//   OUT_VALID/OUT_READY   execute handshake
//   OUT_PC                PC of the decoded instruction
//   OUT_RS1/RS2/RD        register indices (raw instruction fields)
//   OUT_FUNCT3            raw funct3 (branch condition, load/store width)
//   OUT_IMM               immediate, sign-extended to XLEN
//   OUT_ALU_CTL           ADD=0 SUB=1 SLL=2 LT=3 LTU=4 XOR=5 SRL=6 SRA=7
//                         OR=8 AND=9
//   OUT_OP1_SEL           0=RS1 1=PC 2=zero
//   OUT_OP2_SEL           0=RS2 1=IMM 2=const 4
//   OUT_DIN_SEL           0=ALU 1=MEM 2=PC+4
//   OUT_PC_SEL            0=PC+4 1=branch 2=JAL 3=JALR
//   OUT_MM_WR             0=none 1=load 2=store
//   OUT_REG_WR            register-file write enable
//   OUT_ILLEGAL           undecodable instruction
//   OUT_MDU_EN/MDU_OP     multiply/divide enable and function (= funct3)
//
// Build option
//   DEC_RV32M_EN  when defined, OP with funct7=0000001 decodes as an MDU
//                 operation.  When undefined it is illegal and the MDU
//                 outputs stay 0.
// ---------------------------------------------------------------------------
module rv_decode_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_VAL = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INSTR,
  input  logic [XLEN-1:0] IN_PC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_PC,
  output logic [4:0]      OUT_RS1,
  output logic [4:0]      OUT_RS2,
  output logic [4:0]      OUT_RD,
  output logic [2:0]      OUT_FUNCT3,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [3:0]      OUT_ALU_CTL,
  output logic [1:0]      OUT_OP1_SEL,
  output logic [1:0]      OUT_OP2_SEL,
  output logic [1:0]      OUT_DIN_SEL,
  output logic [1:0]      OUT_PC_SEL,
  output logic [1:0]      OUT_MM_WR,
  output logic            OUT_REG_WR,
  output logic            OUT_ILLEGAL,
  output logic            OUT_MDU_EN,
  output logic [2:0]      OUT_MDU_OP
);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU control codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_LT  = 4'd3;
  localparam logic [3:0] ALU_LTU = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;

  // Mux select encodings
  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;
  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] DIN_ALU  = 2'd0;
  localparam logic [1:0] DIN_MEM  = 2'd1;
  localparam logic [1:0] DIN_PC4  = 2'd2;
  localparam logic [1:0] PCS_SEQ  = 2'd0;
  localparam logic [1:0] PCS_BR   = 2'd1;
  localparam logic [1:0] PCS_JAL  = 2'd2;
  localparam logic [1:0] PCS_JALR = 2'd3;
  localparam logic [1:0] MM_NONE  = 2'd0;
  localparam logic [1:0] MM_LOAD  = 2'd1;
  localparam logic [1:0] MM_STORE = 2'd2;

  // One decoded beat; both buffer entries hold this, never the raw word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_ctl;
    logic [1:0]      op1_sel;
    logic [1:0]      op2_sel;
    logic [1:0]      din_sel;
    logic [1:0]      pc_sel;
    logic [1:0]      mm_wr;
    logic            reg_wr;
    logic            illegal;
    logic            mdu_en;
    logic [2:0]      mdu_op;
  } dec_t;

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm_wide;
  logic        legal;
  logic        shamt_hi_bad;
  dec_t        dec_core;
  dec_t        dec_beat;

  assign opcode = IN_INSTR[6:0];
  assign funct3 = IN_INSTR[14:12];
  assign funct7 = IN_INSTR[31:25];

  assign imm_i = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
  assign imm_s = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
  assign imm_b = {{19{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[7],
                  IN_INSTR[30:25], IN_INSTR[11:8], 1'b0};
  assign imm_u = {IN_INSTR[31:12], 12'b0};
  assign imm_j = {{11{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[19:12],
                  IN_INSTR[20], IN_INSTR[30:21], 1'b0};

  // RV32 shift amounts are 5 bits; bit 25 set on a shift-immediate would be
  // a 6-bit shamt, which only RV64 can encode.
  assign shamt_hi_bad = (XLEN == 32) ? IN_INSTR[25] : 1'b0;

  // Every immediate is built at 32 bits (all are sign-extended from bit 31)
  // and widened once here.
  generate
    if (XLEN == 32) begin : g_imm_native
      assign imm_wide = imm32;
    end else begin : g_imm_extend
      assign imm_wide = {{(XLEN-32){imm32[31]}}, imm32};
    end
  endgenerate

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_LT;
      3'b011:  code = ALU_LTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  always_comb begin
    dec_core        = '0;
    dec_core.pc     = IN_PC;
    dec_core.rs1    = IN_INSTR[19:15];
    dec_core.rs2    = IN_INSTR[24:20];
    dec_core.rd     = IN_INSTR[11:7];
    dec_core.funct3 = funct3;
    imm32           = '0;
    legal           = 1'b0;

    case (opcode)
      OPC_LUI: begin
        legal            = 1'b1;
        imm32            = imm_u;
        dec_core.op1_sel = OP1_ZERO;
        dec_core.op2_sel = OP2_IMM;
        dec_core.reg_wr  = 1'b1;
      end
      OPC_AUIPC: begin
        legal            = 1'b1;
        imm32            = imm_u;
        dec_core.op1_sel = OP1_PC;
        dec_core.op2_sel = OP2_IMM;
        dec_core.reg_wr  = 1'b1;
      end
      OPC_JAL: begin
        // ALU forms the target PC+imm; the link value comes from PC+4.
        legal            = 1'b1;
        imm32            = imm_j;
        dec_core.op1_sel = OP1_PC;
        dec_core.op2_sel = OP2_IMM;
        dec_core.din_sel = DIN_PC4;
        dec_core.pc_sel  = PCS_JAL;
        dec_core.reg_wr  = 1'b1;
      end
      OPC_JALR: begin
        legal            = 1'b1;
        imm32            = imm_i;
        dec_core.op2_sel = OP2_IMM;
        dec_core.din_sel = DIN_PC4;
        dec_core.pc_sel  = PCS_JALR;
        dec_core.reg_wr  = 1'b1;
      end
      OPC_BRANCH: begin
        // ALU compares RS1/RS2; funct3 selects the condition downstream.
        legal           = 1'b1;
        imm32           = imm_b;
        dec_core.pc_sel = PCS_BR;
        case (funct3[2:1])
          2'b10:   dec_core.alu_ctl = ALU_LT;
          2'b11:   dec_core.alu_ctl = ALU_LTU;
          default: dec_core.alu_ctl = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        legal            = 1'b1;
        imm32            = imm_i;
        dec_core.op2_sel = OP2_IMM;
        dec_core.din_sel = DIN_MEM;
        dec_core.mm_wr   = MM_LOAD;
        dec_core.reg_wr  = 1'b1;
      end
      OPC_STORE: begin
        legal            = 1'b1;
        imm32            = imm_s;
        dec_core.op2_sel = OP2_IMM;
        dec_core.mm_wr   = MM_STORE;
      end
      OPC_OP_IMM: begin
        imm32            = imm_i;
        dec_core.op2_sel = OP2_IMM;
        dec_core.reg_wr  = 1'b1;
        dec_core.alu_ctl = alu_from_f3(funct3);
        case (funct3)
          3'b001: legal = (IN_INSTR[31:26] == 6'b000000) && !shamt_hi_bad;
          3'b101: begin
            if (IN_INSTR[31:26] == 6'b010000) begin
              legal            = !shamt_hi_bad;
              dec_core.alu_ctl = ALU_SRA;
            end else begin
              legal = (IN_INSTR[31:26] == 6'b000000) && !shamt_hi_bad;
            end
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec_core.reg_wr  = 1'b1;
        dec_core.alu_ctl = alu_from_f3(funct3);
        case (funct7)
          7'b0000000: legal = 1'b1;
          7'b0100000: begin
            // Only ADD and SRL have an alternate form (SUB, SRA).
            if (funct3 == 3'b000) begin
              legal            = 1'b1;
              dec_core.alu_ctl = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              legal            = 1'b1;
              dec_core.alu_ctl = ALU_SRA;
            end
          end
          7'b0000001: begin
`ifdef DEC_RV32M_EN
            legal            = 1'b1;
            dec_core.alu_ctl = ALU_ADD;
            dec_core.mdu_en  = 1'b1;
            dec_core.mdu_op  = funct3;
`else
            legal = 1'b0;
`endif
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    // An illegal beat still flows down the pipe, but must not change any
    // architectural state; register fields and immediate are left as found.
    if (!legal) begin
      dec_core.illegal = 1'b1;
      dec_core.alu_ctl = ALU_ADD;
      dec_core.op1_sel = OP1_RS1;
      dec_core.op2_sel = OP2_RS2;
      dec_core.din_sel = DIN_ALU;
      dec_core.pc_sel  = PCS_SEQ;
      dec_core.mm_wr   = MM_NONE;
      dec_core.reg_wr  = 1'b0;
      dec_core.mdu_en  = 1'b0;
      dec_core.mdu_op  = 3'b000;
    end
  end

  always_comb begin
    dec_beat     = dec_core;
    dec_beat.imm = imm_wide;
  end

  // -------------------------------------------------------------------------
  // Two-entry buffer
  // -------------------------------------------------------------------------
  dec_t main_reg, main_next;
  dec_t skid_reg, skid_next;
  logic main_valid_reg, main_valid_next;
  logic skid_valid_reg, skid_valid_next;
  logic in_ready_reg, in_ready_next;
  logic accept, consume;

  assign accept  = IN_VALID & in_ready_reg;
  assign consume = main_valid_reg & OUT_READY;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;

    if (FLUSH) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || consume) begin
      // Main is free at this edge. The skid beat is older, so it goes first;
      // IN_READY is low while skid is full, so accept cannot collide here.
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next       = dec_beat;
        main_valid_next = 1'b1;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = dec_beat;
      skid_valid_next = 1'b1;
    end

    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: everything reads 0 (PC reads RESET_PC_VAL) while main is empty.
  // -------------------------------------------------------------------------
  dec_t out_beat;

  always_comb begin
    out_beat = main_reg;
    if (!main_valid_reg) begin
      out_beat    = '0;
      out_beat.pc = RESET_PC_VAL;
    end
  end

  assign IN_READY    = in_ready_reg;
  assign OUT_VALID   = main_valid_reg;
  assign OUT_PC      = out_beat.pc;
  assign OUT_RS1     = out_beat.rs1;
  assign OUT_RS2     = out_beat.rs2;
  assign OUT_RD      = out_beat.rd;
  assign OUT_FUNCT3  = out_beat.funct3;
  assign OUT_IMM     = out_beat.imm;
  assign OUT_ALU_CTL = out_beat.alu_ctl;
  assign OUT_OP1_SEL = out_beat.op1_sel;
  assign OUT_OP2_SEL = out_beat.op2_sel;
  assign OUT_DIN_SEL = out_beat.din_sel;
  assign OUT_PC_SEL  = out_beat.pc_sel;
  assign OUT_MM_WR   = out_beat.mm_wr;
  assign OUT_REG_WR  = out_beat.reg_wr;
  assign OUT_ILLEGAL = out_beat.illegal;
  assign OUT_MDU_EN  = out_beat.mdu_en;
  assign OUT_MDU_OP  = out_beat.mdu_op;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage
// ---------------------------------------------------------------------------
// Self-checking bench for rv_decode_stage.  Directed beats from the test plan
// are followed by a randomized phase.  Every accepted beat is decoded by a
// reference model (integer arithmetic on the instruction word) and queued;
// every consumed beat is compared against the queue head.  Buffer occupancy
// is the queue length, which also predicts IN_READY and OUT_VALID.
// ---------------------------------------------------------------------------
module tb_rv_decode_stage;

  localparam int              XLEN   = 32;
  localparam logic [XLEN-1:0] RST_PC = XLEN'(32'h0000_0200);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [2:0]      out_funct3;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_ctl;
  logic [1:0]      out_op1_sel, out_op2_sel, out_din_sel, out_pc_sel, out_mm_wr;
  logic            out_reg_wr, out_illegal, out_mdu_en;
  logic [2:0]      out_mdu_op;

  rv_decode_stage #(.XLEN(XLEN), .RESET_PC_VAL(RST_PC)) dut (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_INSTR(in_instr), .IN_PC(in_pc),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_PC(out_pc),
    .OUT_RS1(out_rs1), .OUT_RS2(out_rs2), .OUT_RD(out_rd),
    .OUT_FUNCT3(out_funct3), .OUT_IMM(out_imm), .OUT_ALU_CTL(out_alu_ctl),
    .OUT_OP1_SEL(out_op1_sel), .OUT_OP2_SEL(out_op2_sel),
    .OUT_DIN_SEL(out_din_sel), .OUT_PC_SEL(out_pc_sel), .OUT_MM_WR(out_mm_wr),
    .OUT_REG_WR(out_reg_wr), .OUT_ILLEGAL(out_illegal),
    .OUT_MDU_EN(out_mdu_en), .OUT_MDU_OP(out_mdu_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic [1:0]      op1, op2, din, pcs, mm;
    logic            reg_wr, illegal, mdu_en;
    logic [2:0]      mdu_op;
  } exp_t;

  exp_t            q[$];
  logic [XLEN-1:0] popped_pc[$];
  int              n_checks = 0;
  int              n_pass = 0;
  bit              last_acc = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = {out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_imm, out_alu_ctl,
         out_op1_sel, out_op2_sel, out_din_sel, out_pc_sel, out_mm_wr,
         out_reg_wr, out_illegal, out_mdu_en, out_mdu_op};
    return o;
  endfunction

  // Reference decoder: immediates by arithmetic on the sign-extended word.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [XLEN-1:0] pc);
    exp_t   e;
    longint sx, imm;
    int     op, f3, f7, top6;
    bit     ok;
    int     alu_tab[8];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    e = '0;
    e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.funct3 = w[14:12];
    sx = longint'($signed(w));
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]); top6 = int'(w[31:26]);
    imm = 0; ok = 1'b1;
    case (op)
      'h37: begin imm = (sx >>> 12) << 12; e.op1 = 2; e.op2 = 1; e.reg_wr = 1; end
      'h17: begin imm = (sx >>> 12) << 12; e.op1 = 1; e.op2 = 1; e.reg_wr = 1; end
      'h6f: begin
        imm = ((sx >>> 31) << 20) | (longint'(w[19:12]) << 12) |
              (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
        e.op1 = 1; e.op2 = 1; e.din = 2; e.pcs = 2; e.reg_wr = 1;
      end
      'h67: begin imm = sx >>> 20; e.op2 = 1; e.din = 2; e.pcs = 3; e.reg_wr = 1; end
      'h63: begin
        imm = ((sx >>> 31) << 12) | (longint'(w[7]) << 11) |
              (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
        e.pcs = 1;
        e.alu = (f3 >= 6) ? 4'd4 : (f3 >= 4) ? 4'd3 : 4'd1;
      end
      'h03: begin imm = sx >>> 20; e.op2 = 1; e.din = 1; e.mm = 1; e.reg_wr = 1; end
      'h23: begin imm = ((sx >>> 25) << 5) | longint'(w[11:7]); e.op2 = 1; e.mm = 2; end
      'h13: begin
        imm = sx >>> 20; e.op2 = 1; e.reg_wr = 1; e.alu = 4'(alu_tab[f3]);
        if (f3 == 1) ok = (top6 == 0);
        if (f3 == 5) begin
          if (top6 == 16) e.alu = 4'd7;
          else ok = (top6 == 0);
        end
        if ((f3 == 1 || f3 == 5) && XLEN == 32 && w[25]) ok = 1'b0;
      end
      'h33: begin
        e.reg_wr = 1; e.alu = 4'(alu_tab[f3]);
        if (f7 == 0) ok = 1'b1;
        else if (f7 == 32) begin
          if (f3 == 0) e.alu = 4'd1;
          else if (f3 == 5) e.alu = 4'd7;
          else ok = 1'b0;
        end else if (f7 == 1) begin
`ifdef DEC_RV32M_EN
          e.alu = 4'd0; e.mdu_en = 1'b1; e.mdu_op = w[14:12];
`else
          ok = 1'b0;
`endif
        end else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    e.imm = imm[XLEN-1:0];
    if (!ok) begin
      e.illegal = 1'b1; e.alu = 0; e.op1 = 0; e.op2 = 0; e.din = 0; e.pcs = 0;
      e.mm = 0; e.reg_wr = 0; e.mdu_en = 0; e.mdu_op = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[9];
    int          k;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = ops[k];
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (w[6:0] == 7'h13 && w[13:12] == 2'b01) begin
      case ($urandom_range(0, 2))
        0: w[31:26] = 6'h00;
        1: w[31:26] = 6'h10;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic drive(input bit v, input logic [31:0] w, input logic [XLEN-1:0] pc);
    in_valid = v; in_instr = w; in_pc = pc;
  endtask

  // One clock: check handshake and consumed beat at the falling edge, update
  // the scoreboard, then return 1 time unit after the rising edge.
  task automatic step();
    bit exp_rdy, exp_vld;
    @(negedge clk);
    exp_rdy = (q.size() < 2);
    exp_vld = (q.size() != 0);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_vld);
    if (exp_vld && out_ready) begin
      check("beat", observed(), q[0]);
      popped_pc.push_back(q[0].pc);
      void'(q.pop_front());
    end
    last_acc = in_valid && exp_rdy;
    if (flush) q.delete();
    else if (last_acc) q.push_back(ref_decode(in_instr, in_pc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] ones, minus4;
    int n;
    ones = '1;
    minus4 = ones - XLEN'(3);

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, RST_PC);
    check("rst_imm", out_imm, 0);
    check("rst_reg_wr", out_reg_wr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", in_ready, 0);
    @(posedge clk);
    #1;

    // add x3,x1,x2
    out_ready = 1'b1;
    drive(1, 32'h002081B3, XLEN'(32'h100));
    step();
    check("add_valid", out_valid, 1);
    check("add_rs1", out_rs1, 1);
    check("add_rs2", out_rs2, 2);
    check("add_rd", out_rd, 3);
    check("add_alu", out_alu_ctl, 0);
    check("add_op2", out_op2_sel, 0);
    check("add_reg_wr", out_reg_wr, 1);
    check("add_imm", out_imm, 0);

    // sub then addi x1,x0,-1 back-to-back
    drive(1, 32'h402081B3, XLEN'(32'h104));
    step();
    check("sub_alu", out_alu_ctl, 1);
    drive(1, 32'hFFF00093, XLEN'(32'h108));
    step();
    check("li_imm", out_imm, ones);
    check("li_op2", out_op2_sel, 1);
    check("li_rd", out_rd, 1);

    // beq x1,x2,-4
    drive(1, 32'hFE208EE3, XLEN'(32'h10c));
    step();
    check("beq_imm", out_imm, minus4);
    check("beq_pc_sel", out_pc_sel, 1);
    check("beq_funct3", out_funct3, 0);
    check("beq_reg_wr", out_reg_wr, 0);

    // all-zero word, then mul x3,x1,x2
    drive(1, 32'h00000000, XLEN'(32'h110));
    step();
    check("zero_illegal", out_illegal, 1);
    check("zero_reg_wr", out_reg_wr, 0);
    check("zero_mm_wr", out_mm_wr, 0);
    drive(1, 32'h022081B3, XLEN'(32'h114));
    step();
`ifdef DEC_RV32M_EN
    check("mul_mdu_en", out_mdu_en, 1);
    check("mul_mdu_op", out_mdu_op, 0);
    check("mul_illegal", out_illegal, 0);
`else
    check("mul_illegal", out_illegal, 1);
    check("mul_mdu_en", out_mdu_en, 0);
`endif
    drive(0, 0, 0);
    step();

    // Back-pressure: three beats with OUT_READY low
    popped_pc.delete();
    out_ready = 1'b0;
    drive(1, 32'h00100093, XLEN'(32'h200));
    step();
    drive(1, 32'h00200113, XLEN'(32'h204));
    step();
    check("bp_ready_low", in_ready, 0);
    drive(1, 32'h00300193, XLEN'(32'h208));
    step();
    check("bp_hold", last_acc, 0);
    out_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (!last_acc && n < 8);
    check("bp_accept_c", last_acc, 1);
    drive(0, 0, 0);
    n = 0;
    while (q.size() != 0 && n < 8) begin step(); n++; end
    check("bp_count", popped_pc.size(), 3);
    if (popped_pc.size() == 3) begin
      check("bp_order0", popped_pc[0], XLEN'(32'h200));
      check("bp_order1", popped_pc[1], XLEN'(32'h204));
      check("bp_order2", popped_pc[2], XLEN'(32'h208));
    end

    // Flush with two beats buffered and a third offered
    out_ready = 1'b0;
    drive(1, 32'h00400213, XLEN'(32'h300));
    step();
    drive(1, 32'h00500293, XLEN'(32'h304));
    step();
    flush = 1'b1;
    drive(1, 32'h00600313, XLEN'(32'h308));
    step();
    flush = 1'b0;
    drive(0, 0, 0);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    popped_pc.delete();
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_no_beats", popped_pc.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), XLEN'({$urandom, $urandom}));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 79) == 0);
      step();
    end
    flush = 1'b0;
    drive(0, 0, 0);
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 10) begin step(); n++; end
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
